mem_req_ctrl: RTL and testbench
===============================

MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 SHALL provide parameter RD_LAT, default 49: cycles from raddr0_ presented to matching rdata0_ valid.
REQ-002 SHALL provide parameter TAG_W, default 4: request/response tag width.
REQ-003 SHALL provide parameter RSP_DEPTH, default 8: response FIFO depth and load-credit limit; a power of two and at least 2.
REQ-004 SHALL have a single clock and a synchronous, active-high reset.
REQ-005 clk  input  1  sole clock; all state updates on posedge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req_valid_  input  1  core request valid.
REQ-008 req_ready_  output  1  request accepted when valid&ready.
REQ-009 req_we_  input  1  1=store, 0=load.
REQ-010 req_addr_  input  [15:1]  word address.
REQ-011 req_wdata_  input  16  store data.
REQ-012 req_tag_  input  TAG_W  load tag, returned with response.
REQ-013 rsp_valid_  output  1  load response valid.
REQ-014 rsp_ready_  input  1  core accepts response.
REQ-015 rsp_data_  output  16  load data.
REQ-016 rsp_tag_  output  TAG_W  tag of returned load.
REQ-017 raddr0_  output  [15:1]  memory read address.
REQ-018 rdata0_  input  16  memory read data, RD_LAT cycles after raddr0_.
REQ-019 wen_  output  1  memory write enable.
REQ-020 waddr_  output  [15:1]  memory write address.
REQ-021 wdata_  output  16  memory write data.

Function
REQ-022 SHALL treat outstanding = in-flight loads + FIFO occupancy; counters sized clog2(RSP_DEPTH+1).
REQ-023 SHALL drive req_ready_ = !rst & (req_we_ | outstanding < RSP_DEPTH); stores are never back-pressured.
REQ-024 Store accepted at cycle T: wen_=1, waddr_/wdata_ = request for exactly cycle T+1; wen_=0 otherwise.
REQ-025 Load accepted at T: raddr0_=req_addr_ during T+1 and held until next load; {valid,tag} enters a delay line of RD_LAT+1 stages.
REQ-026 SHALL sample rdata0_ at end of T+1+RD_LAT and push {rdata0_,tag} into FIFO; rsp_valid_ earliest at T+2+RD_LAT (no bypass).
REQ-027 Responses SHALL return in acceptance order; tags are opaque, never checked.
REQ-028 rsp_valid_ = FIFO non-empty; pop on rsp_valid_&rsp_ready_; rsp_data_/rsp_tag_ stable while rsp_valid_&!rsp_ready_.
REQ-029 Simultaneous push and pop SHALL keep occupancy unchanged, including when full; pointers wrap mod RSP_DEPTH.
REQ-030 Credit rule SHALL guarantee no FIFO overflow; push when full is an assertion failure.
REQ-031 Load accepted after a store to the same address SHALL return the stored data; load accepted before it SHALL return the old data.
REQ-032 Back-to-back loads SHALL be accepted every cycle while credits remain; stores may interleave in any cycle.

Reset
REQ-033 While rst=1: req_ready_=0, rsp_valid_=0, wen_=0, raddr0_=0, waddr_=0, wdata_=0, rsp_data_=0, rsp_tag_=0.
REQ-034 Reset SHALL clear delay-line valid bits, FIFO pointers and occupancy; in-flight loads are discarded and late rdata0_ ignored.
REQ-035 First request SHALL be accepted in the cycle after rst deasserts.

Verification
REQ-036 Single load addr 0x0003 (mem=0xBEEF), tag 5, rsp_ready_=1 -> rsp_valid_ at T+51 with data 0xBEEF, tag 5, one cycle only.
REQ-037 Store 0x1234 to 0x0010 at T, load 0x0010 at T+1 -> wen_ high at T+1 only; response data 0x1234.
REQ-038 rsp_ready_=0, 10 loads offered back-to-back -> exactly 8 accepted, req_ready_=0 for loads after, stores still accepted; release ready -> 8 responses in order, tags 0..7.
REQ-039 Full FIFO with simultaneous pop and push -> occupancy stays 8, no data loss or duplication.
REQ-040 rst pulsed 20 cycles after 3 loads accepted -> no rsp_valid_ ever appears for them; outputs zero during rst; new load after reset returns correctly.

Source files
------------

// File: rtl/mem_req_ctrl.sv
// Memory request controller: forwards stores, issues loads to a fixed-latency
// read port and returns load data in order through a credit-limited response FIFO.
module mem_req_ctrl #(
   parameter int unsigned RD_LAT    = 49,
   parameter int unsigned TAG_W     = 4,
   parameter int unsigned RSP_DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid_,
   output logic             req_ready_,
   input  logic             req_we_,
   input  logic [15:1]      req_addr_,
   input  logic [15:0]      req_wdata_,
   input  logic [TAG_W-1:0] req_tag_,
   output logic             rsp_valid_,
   input  logic             rsp_ready_,
   output logic [15:0]      rsp_data_,
   output logic [TAG_W-1:0] rsp_tag_,
   output logic [15:1]      raddr0_,
   input  logic [15:0]      rdata0_,
   output logic             wen_,
   output logic [15:1]      waddr_,
   output logic [15:0]      wdata_
);

   localparam int unsigned CW  = $clog2(RSP_DEPTH + 1);
   localparam int unsigned PW  = $clog2(RSP_DEPTH);
   localparam int unsigned EW  = 16 + TAG_W;
   localparam int unsigned DLW = (RD_LAT + 1) * TAG_W;

   logic [CW-1:0]    inflight_q;
   logic [CW-1:0]    count_q;
   logic [CW:0]      outstanding;
   logic             accept;
   logic             load_acc;
   logic             store_acc;
   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_nempty;
   logic [RD_LAT:0]  dl_vld_q;
   logic [DLW-1:0]   dl_tag_q;
   logic [EW-1:0]    fifo_q [RSP_DEPTH];
   logic [EW-1:0]    head;
   logic [PW-1:0]    wptr_q;
   logic [PW-1:0]    rptr_q;
   logic             wen_q;
   logic [15:1]      waddr_q;
   logic [15:0]      wdata_q;
   logic [15:1]      raddr_q;

   // Credits cover every load not yet handed back, so the FIFO can never overflow.
   assign outstanding = (CW+1)'(inflight_q) + (CW+1)'(count_q);
   assign req_ready_  = !rst && (req_we_ || (outstanding < (CW+1)'(RSP_DEPTH)));
   assign accept      = req_valid_ && req_ready_;
   assign load_acc    = accept && !req_we_;
   assign store_acc   = accept && req_we_;

   assign push        = dl_vld_q[RD_LAT];
   assign fifo_nempty = (count_q != '0);
   assign fifo_full   = (count_q == CW'(RSP_DEPTH));
   assign pop         = fifo_nempty && rsp_ready_;
   assign head        = fifo_q[rptr_q];

   // Load tracking delay line; the last stage lines up with rdata0_.
   always_ff @(posedge clk) begin
      if (rst) begin
         dl_vld_q <= '0;
      end else begin
         dl_vld_q <= (dl_vld_q << 1) | (RD_LAT+1)'(load_acc);
      end
   end

   always_ff @(posedge clk) begin
      dl_tag_q <= (dl_tag_q << TAG_W) | DLW'(req_tag_);
   end

   always_ff @(posedge clk) begin
      if (push && !rst) begin
         fifo_q[wptr_q] <= {rdata0_, dl_tag_q[DLW-1 -: TAG_W]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         inflight_q <= '0;
      end else begin
         assert (!(push && fifo_full));
         if (push) wptr_q <= wptr_q + PW'(1);
         if (pop)  rptr_q <= rptr_q + PW'(1);
         count_q    <= count_q + CW'(push) - CW'(pop);
         inflight_q <= inflight_q + CW'(load_acc) - CW'(push);
      end
   end

   // Memory-side registers: one-cycle write strobe, read address held until the next load.
   always_ff @(posedge clk) begin
      if (rst) begin
         wen_q   <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         raddr_q <= '0;
      end else begin
         wen_q <= store_acc;
         if (store_acc) begin
            waddr_q <= req_addr_;
            wdata_q <= req_wdata_;
         end
         if (load_acc) raddr_q <= req_addr_;
      end
   end

   // Outputs are forced to zero for the whole time reset is held.
   assign wen_       = wen_q && !rst;
   assign waddr_     = rst ? '0 : waddr_q;
   assign wdata_     = rst ? '0 : wdata_q;
   assign raddr0_    = rst ? '0 : raddr_q;
   assign rsp_valid_ = !rst && fifo_nempty;
   assign rsp_data_  = rsp_valid_ ? head[EW-1 -: 16] : '0;
   assign rsp_tag_   = rsp_valid_ ? head[TAG_W-1:0] : '0;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: table of directed store/load pairs, hand-written credit and
// reset sequences, and random traffic checked against a transaction-level reference model.
module tb_mem_req_ctrl;

   localparam int unsigned RD_LAT    = 49;
   localparam int unsigned TAG_W     = 4;
   localparam int unsigned RSP_DEPTH = 8;
   localparam int          HN        = 128;

   logic             clk = 1'b0;
   logic             rst;
   logic             req_valid_;
   logic             req_ready_;
   logic             req_we_;
   logic [15:1]      req_addr_;
   logic [15:0]      req_wdata_;
   logic [TAG_W-1:0] req_tag_;
   logic             rsp_valid_;
   logic             rsp_ready_;
   logic [15:0]      rsp_data_;
   logic [TAG_W-1:0] rsp_tag_;
   logic [15:1]      raddr0_;
   logic [15:0]      rdata0_;
   logic             wen_;
   logic [15:1]      waddr_;
   logic [15:0]      wdata_;

   mem_req_ctrl #(.RD_LAT(RD_LAT), .TAG_W(TAG_W), .RSP_DEPTH(RSP_DEPTH)) dut (
      .clk(clk), .rst(rst),
      .req_valid_(req_valid_), .req_ready_(req_ready_), .req_we_(req_we_),
      .req_addr_(req_addr_), .req_wdata_(req_wdata_), .req_tag_(req_tag_),
      .rsp_valid_(rsp_valid_), .rsp_ready_(rsp_ready_), .rsp_data_(rsp_data_),
      .rsp_tag_(rsp_tag_), .raddr0_(raddr0_), .rdata0_(rdata0_),
      .wen_(wen_), .waddr_(waddr_), .wdata_(wdata_)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] init_val(input int a);
      return (a == 3) ? 16'hBEEF : 16'((a * 37 + 11) ^ 16'h5A5A);
   endfunction

   // Memory with a fixed read latency: data read in cycle c appears on rdata0_ in c+RD_LAT.
   logic [15:0] mem     [0:32767];
   logic [15:0] ref_mem [0:32767];
   logic [15:0] rd_hist [0:HN-1];

   always @(negedge clk) begin
      rd_hist[cyc % HN] = mem[raddr0_];
      rdata0_ = rd_hist[(cyc + HN - int'(RD_LAT)) % HN];
      if (wen_) mem[waddr_] = wdata_;
   end

   // Reference model: every accepted, unconsumed load is one queue entry holding the
   // data the memory held at acceptance time and the first cycle it may be returned.
   logic [15:0]      q_data [$];
   logic [TAG_W-1:0] q_tag  [$];
   int               q_rdy  [$];
   logic             pst_v = 1'b0;
   logic [15:1]      pst_a;
   logic [15:0]      pst_d;
   logic [15:1]      last_ld = '0;

   always @(negedge clk) begin : monitor
      logic exp_rdy;
      logic exp_vld;
      if (rst) begin
         chk("rst_req_ready", req_ready_, 0);
         chk("rst_rsp_valid", rsp_valid_, 0);
         chk("rst_wen", wen_, 0);
         chk("rst_raddr0", raddr0_, 0);
         chk("rst_waddr", waddr_, 0);
         chk("rst_wdata", wdata_, 0);
         chk("rst_rsp_data", rsp_data_, 0);
         chk("rst_rsp_tag", rsp_tag_, 0);
         q_data.delete();
         q_tag.delete();
         q_rdy.delete();
         pst_v   = 1'b0;
         last_ld = '0;
      end else begin
         exp_rdy = req_we_ || (q_data.size() < RSP_DEPTH);
         exp_vld = (q_data.size() > 0) && (q_rdy[0] <= cyc);
         chk("req_ready", req_ready_, exp_rdy);
         chk("rsp_valid", rsp_valid_, exp_vld);
         if (exp_vld) begin
            chk("rsp_data", rsp_data_, q_data[0]);
            chk("rsp_tag", rsp_tag_, q_tag[0]);
         end
         chk("wen", wen_, pst_v);
         if (pst_v) begin
            chk("waddr", waddr_, pst_a);
            chk("wdata", wdata_, pst_d);
         end
         chk("raddr0", raddr0_, last_ld);
         if (exp_vld && rsp_ready_) begin
            void'(q_data.pop_front());
            void'(q_tag.pop_front());
            void'(q_rdy.pop_front());
         end
         pst_v = 1'b0;
         if (req_valid_ && exp_rdy) begin
            if (req_we_) begin
               ref_mem[req_addr_] = req_wdata_;
               pst_v = 1'b1;
               pst_a = req_addr_;
               pst_d = req_wdata_;
            end else begin
               q_data.push_back(ref_mem[req_addr_]);
               q_tag.push_back(req_tag_);
               q_rdy.push_back(cyc + 2 + int'(RD_LAT));
               last_ld = req_addr_;
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic we, input logic [15:1] a,
                        input logic [15:0] d, input logic [TAG_W-1:0] t);
      req_valid_ = v;
      req_we_    = we;
      req_addr_  = a;
      req_wdata_ = d;
      req_tag_   = t;
   endtask

   task automatic idle;
      drive(1'b0, 1'b0, '0, '0, '0);
   endtask

   typedef struct {
      logic             st_en;
      logic             ld_first;
      logic [15:1]      st_addr;
      logic [15:0]      st_data;
      logic [15:1]      ld_addr;
      logic [TAG_W-1:0] ld_tag;
      logic [15:0]      exp_data;
   } vec_t;

   // Issue the row's two requests back to back, then time and check the load response.
   task automatic run_row(input vec_t v, input int idx);
      int   t_ld;
      int   t_seen;
      logic seen;
      t_ld = 0;
      t_seen = 0;
      if (!v.st_en || v.ld_first) begin
         drive(1'b1, 1'b0, v.ld_addr, '0, v.ld_tag);
         t_ld = cyc;
         tick;
         if (v.st_en) begin
            drive(1'b1, 1'b1, v.st_addr, v.st_data, '0);
            tick;
         end
      end else begin
         drive(1'b1, 1'b1, v.st_addr, v.st_data, '0);
         tick;
         drive(1'b1, 1'b0, v.ld_addr, '0, v.ld_tag);
         t_ld = cyc;
         tick;
      end
      idle;
      seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
         if (rsp_valid_) begin
            seen = 1'b1;
            t_seen = cyc;
         end else begin
            tick;
         end
      end
      chk($sformatf("row%0d_seen", idx), seen, 1);
      if (seen) begin
         chk($sformatf("row%0d_latency", idx), t_seen - t_ld, 2 + RD_LAT);
         chk($sformatf("row%0d_data", idx), rsp_data_, v.exp_data);
         chk($sformatf("row%0d_tag", idx), rsp_tag_, v.ld_tag);
         tick;
         chk($sformatf("row%0d_one_cycle", idx), rsp_valid_, 0);
      end
      repeat (2) tick;
   endtask

   vec_t vt [6];

   initial begin : watchdog
      #2000000;
      errors++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : stim
      int n_acc;
      int n;
      int bias;
      for (int i = 0; i < 32768; i++) begin
         mem[i]     = init_val(i);
         ref_mem[i] = init_val(i);
      end
      rst = 1'b1;
      rsp_ready_ = 1'b1;
      idle;
      repeat (3) tick;
      rst = 1'b0;

      vt[0] = '{1'b0, 1'b1, 15'h0000, 16'h0000, 15'h0003, 4'd5,  16'hBEEF};
      vt[1] = '{1'b1, 1'b0, 15'h0010, 16'h1234, 15'h0010, 4'd2,  16'h1234};
      vt[2] = '{1'b1, 1'b1, 15'h0020, 16'hCAFE, 15'h0020, 4'd3,  init_val(32'h20)};
      vt[3] = '{1'b0, 1'b1, 15'h0000, 16'h0000, 15'h0020, 4'd4,  16'hCAFE};
      vt[4] = '{1'b1, 1'b0, 15'h7FFF, 16'hFFFF, 15'h7FFF, 4'd15, 16'hFFFF};
      vt[5] = '{1'b1, 1'b0, 15'h0000, 16'h0001, 15'h0001, 4'd0,  init_val(1)};
      for (int i = 0; i < 6; i++) run_row(vt[i], i);

      // Credit limit with the consumer stalled, then in-order drain.
      rsp_ready_ = 1'b0;
      n_acc = 0;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b0, 15'(256 + i), '0, TAG_W'(i));
         #1;
         chk("credit_ready", req_ready_, (i < 8) ? 1 : 0);
         if (req_ready_) n_acc++;
         tick;
      end
      chk("credit_accepted", n_acc, 8);
      drive(1'b1, 1'b1, 15'h0200, 16'h5555, '0);
      #1;
      chk("store_while_full", req_ready_, 1);
      tick;
      drive(1'b1, 1'b0, 15'h0201, '0, '0);
      #1;
      chk("load_blocked", req_ready_, 0);
      tick;
      idle;
      repeat (60) tick;
      chk("full_valid", rsp_valid_, 1);
      repeat (3) tick;
      chk("hold_tag", rsp_tag_, 0);
      chk("hold_data", rsp_data_, init_val(256));
      rsp_ready_ = 1'b1;
      n = 0;
      for (int k = 0; k < 40 && n < 8; k++) begin
         if (rsp_valid_) begin
            chk("order_tag", rsp_tag_, n);
            n++;
         end
         tick;
      end
      chk("drain_count", n, 8);
      chk("drain_empty", rsp_valid_, 0);

      // Full FIFO while the consumer and new loads run every cycle.
      rsp_ready_ = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b0, 15'(768 + i), '0, TAG_W'(8 + i));
         tick;
      end
      idle;
      repeat (60) tick;
      n = 0;
      for (int k = 0; k < 70; k++) begin
         rsp_ready_ = 1'b1;
         drive(1'b1, 1'b0, 15'(1024 + k), '0, '0);
         if (rsp_valid_ && n < 8) begin
            chk("full_order_tag", rsp_tag_, 8 + n);
            n++;
         end
         tick;
      end
      chk("full_order_count", n, 8);
      idle;
      repeat (70) tick;

      // Reset with loads in flight: they must vanish, and the bench restarts cleanly.
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, 1'b0, 15'(i), '0, TAG_W'(i));
         tick;
      end
      idle;
      repeat (20) tick;
      rst = 1'b1;
      repeat (2) tick;
      rst = 1'b0;
      drive(1'b1, 1'b0, 15'h0003, '0, 4'd9);
      #1;
      chk("post_rst_ready", req_ready_, 1);
      tick;
      idle;
      n = 0;
      for (int k = 1; k < 100; k++) begin
         if (rsp_valid_) begin
            n++;
            chk("post_rst_latency", k, 2 + RD_LAT);
            chk("post_rst_tag", rsp_tag_, 9);
            chk("post_rst_data", rsp_data_, 16'hBEEF);
         end
         tick;
      end
      chk("post_rst_rsp_count", n, 1);

      // Random mixed traffic, with periodic stalled-consumer windows to hit the credit limit.
      for (int k = 0; k < 2500; k++) begin
         bias = ((k / 150) % 3 == 1) ? 0 : 6;
         rsp_ready_ = ($urandom_range(0, 9) < bias);
         drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
               ($urandom_range(0, 19) == 0) ? 15'h7FFF : 15'($urandom_range(0, 15)),
               16'($urandom), TAG_W'($urandom));
         tick;
      end
      idle;
      rsp_ready_ = 1'b1;
      repeat (120) tick;
      chk("final_model_empty", q_data.size(), 0);
      chk("final_rsp_valid", rsp_valid_, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
